uart_rx_deframer: RTL and testbench
===================================

# uart_rx_deframer

Parametrised UART receive deframer with buffering. It takes a complete parallel frame from the receive shift register when the received strobe pulses and splits it into data, parity and stop fields. It checks parity and framing, detects breaks, and queues each result with its error flags in a show-ahead FIFO behind a valid/ready interface toward the host side. Sticky overrun status and saturating statistics counters are included.

## Interface
Parameters:
- DATA_W, 8: data bits per frame, legal 5..9.
- PARITY_EN, 1: 1 = frame carries a parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries; power of two, at least 2.
- Derived FRAME_W = 1 + DATA_W + PARITY_EN + STOP_BITS; LVL_W = log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_in  in  FRAME_W  parallel frame: [0] start, [DATA_W:1] data LSB-first, [DATA_W+1] parity (if enabled), top STOP_BITS bits stop.
- frame_valid  in  1  one-cycle strobe: frame_in is complete.
- m_data  out  DATA_W  head-entry data.
- m_parity_err  out  1  head-entry parity mismatch (always 0 if PARITY_EN=0).
- m_frame_err  out  1  head entry: start bit was 1 or any stop bit was 0.
- m_break  out  1  head entry: whole frame was all zeros.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts the head entry.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- clr_overrun  in  1  clears overrun.
- level  out  LVL_W  current FIFO occupancy.
- frame_cnt  out  16  accepted frames, saturating.
- err_cnt  out  16  accepted frames with any error flag set, saturating.

## Operation
- Field decode and checks are combinational on frame_in. Computed parity is XOR(data, parity bit, PARITY_ODD); a nonzero result sets parity_err. Break is frame_in == 0; a break always also sets frame_err.
- Push when frame_valid=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle. The entry is {data, parity_err, frame_err, break}.
- Drop when frame_valid=1, the FIFO is full and there is no pop. The FIFO and counters are unchanged and overrun is set to 1.
- Pop when m_valid=1 and m_ready=1. m_ready is ignored when the FIFO is empty.
- Simultaneous push and pop at any level: level is unchanged, and both pointers advance.
- Pointers are LVL_W bits and wrap modulo 2·FIFO_DEPTH. Full is defined as MSBs differing and the rest equal.
- m_* outputs come from the head entry (show-ahead). When empty, m_valid=0 and the other m_* values are don't-care but must not be X after reset.
- overrun: set on drop, cleared by clr_overrun. If both happen in the same cycle, the set wins.
- frame_cnt increments on every push. err_cnt increments on a push with parity_err|frame_err. Both counters stick at 0xFFFF.
- Frames with errors are still queued; the consumer decides what to do with them.

## Timing
- Reset (async assert, sync release): pointers=0, level=0, m_valid=0, overrun=0, frame_cnt=0, err_cnt=0. FIFO storage is cleared to 0, so m_data=0 and all flags are 0.
- Latency: frame_valid sampled at edge N (FIFO empty) gives m_valid=1 and valid m_* after edge N.
- A pop at edge N exposes the next entry after edge N, with no bubble.
- Back-to-back frame_valid on every cycle is supported at full rate.
- An asserted reset in mid-stream discards all queued entries immediately, without waiting for a clock.

## Test plan
- DATA_W=8, even parity, 1 stop, m_ready=1: frame_in=0x54A with frame_valid pulse -> next cycle m_valid=1, m_data=0xA5, all flags 0, frame_cnt=1, err_cnt=0.
- Parity error: frame_in=0x74A -> m_data=0xA5, m_parity_err=1, m_frame_err=0, err_cnt=1. Then set PARITY_ODD=1 with frame_in=0x74A -> no error.
- Framing and break: frame_in=0x14A -> m_frame_err=1, m_break=0. Then frame_in=0x000 -> m_frame_err=1, m_break=1, m_data=0x00, m_parity_err=0.
- Overrun: FIFO_DEPTH=4, m_ready=0, push frames with data 0x01..0x05 -> level=4, overrun=1, frame_cnt=4. Raise m_ready -> pops 0x01, 0x02, 0x03, 0x04, after which m_valid=0. Pulse clr_overrun -> overrun=0.
- Full with simultaneous push and pop: level=4, frame_valid=1 and m_ready=1 in the same cycle -> no drop, level stays 4, overrun stays 0, new entry appears last.
- Async reset with 3 entries queued, and separately frame_cnt forced near 0xFFFF: asserting rst_n=0 mid-cycle clears level and m_valid immediately. Counter check: 0xFFFE + 3 pushes -> frame_cnt=0xFFFF.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: splits a parallel UART frame into data/parity/stop fields,
// checks parity, framing and break, and queues {data, flags} in a show-ahead
// FIFO with a valid/ready consumer interface.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   frame_in, frame_valid complete frame and its one-cycle strobe
//   m_data, m_parity_err, m_frame_err, m_break, m_valid, m_ready
//                         head entry of the FIFO and handshake
//   overrun, clr_overrun  sticky drop indicator and its clear
//   level                 FIFO occupancy
//   frame_cnt, err_cnt    saturating accepted / errored frame counters
module uart_rx_deframer #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned FRAME_W   = 1 + DATA_W + PARITY_EN + STOP_BITS,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_parity_err,
    output logic               m_frame_err,
    output logic               m_break,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               overrun,
    input  logic               clr_overrun,
    output logic [LVL_W-1:0]   level,
    output logic [15:0]        frame_cnt,
    output logic [15:0]        err_cnt
);

    localparam int unsigned IDX_W = LVL_W - 1;
    localparam int unsigned ENT_W = DATA_W + 3;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Entry layout: {data, parity_err, frame_err, break}
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]  head_q, head_d;
    logic [LVL_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              m_valid_q, m_valid_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;

    logic [DATA_W-1:0] data_c;
    logic              par_bit_c;
    logic              parity_err_c;
    logic              stop_ok_c;
    logic              brk_c;
    logic              frame_err_c;
    logic [ENT_W-1:0]  entry_c;

    logic              empty_c;
    logic              full_c;
    logic              pop_c;
    logic              push_c;
    logic              drop_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic [IDX_W-1:0]  rd_next_idx_c;

    // Field decode and checks on the incoming frame
    always_comb begin
        data_c       = frame_in[DATA_W:1];
        par_bit_c    = (PARITY_EN != 0) ? frame_in[DATA_W+1] : 1'b0;
        parity_err_c = (PARITY_EN != 0) && ((^data_c) ^ par_bit_c ^ (PARITY_ODD != 0));
        stop_ok_c    = &frame_in[FRAME_W-1 -: STOP_BITS];
        brk_c        = (frame_in == '0);
        // An all-zero frame has a zero stop bit, so break implies framing error
        frame_err_c  = frame_in[0] | ~stop_ok_c | brk_c;
        entry_c      = {data_c, parity_err_c, frame_err_c, brk_c};
    end

    // FIFO control, head look-ahead, status and counters
    always_comb begin
        empty_c  = (wr_ptr_q == rd_ptr_q);
        full_c   = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {IDX_W{1'b0}}});
        pop_c    = ~empty_c & m_ready;
        push_c   = frame_valid & (~full_c | pop_c);
        drop_c   = frame_valid & full_c & ~pop_c;
        wr_idx_c = wr_ptr_q[IDX_W-1:0];

        wr_ptr_d = wr_ptr_q + LVL_W'(push_c);
        rd_ptr_d = rd_ptr_q + LVL_W'(pop_c);
        level_d  = wr_ptr_d - rd_ptr_d;
        m_valid_d = (wr_ptr_d != rd_ptr_d);
        rd_next_idx_c = rd_ptr_d[IDX_W-1:0];

        // Registered head: bypass the incoming entry when it lands at the
        // next head slot (only happens when the FIFO drains to it this cycle)
        if (push_c && (wr_idx_c == rd_next_idx_c)) begin
            head_d = entry_c;
        end else begin
            head_d = mem_q[rd_next_idx_c];
        end

        // Set has priority over clear
        overrun_d = drop_c | (overrun_q & ~clr_overrun);

        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (push_c && (frame_cnt_q != CNT_MAX)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (push_c && (parity_err_c | frame_err_c) && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            m_valid_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_idx_c] <= entry_c;
            end
            head_q      <= head_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            m_valid_q   <= m_valid_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign m_data       = head_q[ENT_W-1:3];
    assign m_parity_err = head_q[2];
    assign m_frame_err  = head_q[1];
    assign m_break      = head_q[0];
    assign m_valid      = m_valid_q;
    assign overrun      = overrun_q;
    assign level        = level_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed self-checking bench for uart_rx_deframer (8 data bits, 1 stop,
// depth 4). A second instance with odd parity shares the frame inputs.
module tb_uart_rx_deframer;

    logic        clk;
    logic        rst_n;
    logic [10:0] frame_in;
    logic        frame_valid;
    logic        m_ready;
    logic        clr_overrun;

    logic [7:0]  m_data;
    logic        m_parity_err, m_frame_err, m_break, m_valid, overrun;
    logic [2:0]  level;
    logic [15:0] frame_cnt, err_cnt;

    logic        b_ready;
    logic        b_clr;
    logic [7:0]  b_data;
    logic        b_parity_err, b_frame_err, b_break, b_valid, b_overrun;
    logic [2:0]  b_level;
    logic [15:0] b_frame_cnt, b_err_cnt;

    int n_chk;
    int n_pass;

    uart_rx_deframer #(
        .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_valid(frame_valid),
        .m_data(m_data), .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
        .m_break(m_break), .m_valid(m_valid), .m_ready(m_ready),
        .overrun(overrun), .clr_overrun(clr_overrun), .level(level),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    uart_rx_deframer #(
        .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_odd (
        .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_valid(frame_valid),
        .m_data(b_data), .m_parity_err(b_parity_err), .m_frame_err(b_frame_err),
        .m_break(b_break), .m_valid(b_valid), .m_ready(b_ready),
        .overrun(b_overrun), .clr_overrun(b_clr), .level(b_level),
        .frame_cnt(b_frame_cnt), .err_cnt(b_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Well-formed even-parity frame: {stop=1, parity, data, start=0}
    function automatic logic [10:0] mk(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    // Called at a negedge; returns at the negedge after the capturing edge
    task automatic send(input logic [10:0] f);
        frame_in    = f;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        frame_in = '0;
        frame_valid = 1'b0;
        m_ready = 1'b1;
        clr_overrun = 1'b0;
        b_ready = 1'b1;
        b_clr = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_fcnt", 32'(frame_cnt), 32'd0);
        check("rst_ecnt", 32'(err_cnt), 32'd0);
        check("rst_head", 32'({m_data, m_parity_err, m_frame_err, m_break}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean frame
        send(11'h54A);
        check("ok_valid", 32'(m_valid), 32'd1);
        check("ok_data", 32'(m_data), 32'hA5);
        check("ok_flags", 32'({m_parity_err, m_frame_err, m_break}), 32'd0);
        check("ok_fcnt", 32'(frame_cnt), 32'd1);
        check("ok_ecnt", 32'(err_cnt), 32'd0);

        // Parity bit wrong for even, right for odd
        send(11'h74A);
        check("par_data", 32'(m_data), 32'hA5);
        check("par_perr", 32'(m_parity_err), 32'd1);
        check("par_ferr", 32'(m_frame_err), 32'd0);
        check("par_ecnt", 32'(err_cnt), 32'd1);
        check("odd_valid", 32'(b_valid), 32'd1);
        check("odd_data", 32'(b_data), 32'hA5);
        check("odd_perr", 32'(b_parity_err), 32'd0);

        // Missing stop bit
        send(11'h14A);
        check("fe_ferr", 32'(m_frame_err), 32'd1);
        check("fe_break", 32'(m_break), 32'd0);
        check("fe_perr", 32'(m_parity_err), 32'd0);

        // Break
        send(11'h000);
        check("brk_ferr", 32'(m_frame_err), 32'd1);
        check("brk_break", 32'(m_break), 32'd1);
        check("brk_data", 32'(m_data), 32'h00);
        check("brk_perr", 32'(m_parity_err), 32'd0);
        check("brk_fcnt", 32'(frame_cnt), 32'd4);
        check("brk_ecnt", 32'(err_cnt), 32'd3);
        @(negedge clk);
        check("drain_valid", 32'(m_valid), 32'd0);
        check("drain_level", 32'(level), 32'd0);

        // Overrun: 5 frames into a 4-deep FIFO with no consumer
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            frame_in = mk(8'(i));
            frame_valid = 1'b1;
            @(negedge clk);
        end
        frame_valid = 1'b0;
        check("ovr_level", 32'(level), 32'd4);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_fcnt", 32'(frame_cnt), 32'd8);
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("ovr_pop_valid", 32'(m_valid), 32'd1);
            check("ovr_pop_data", 32'(m_data), 32'(i));
            @(negedge clk);
        end
        check("ovr_empty", 32'(m_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);

        // Full with simultaneous push and pop
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(mk(8'(8'h10 + i)));
        end
        check("fp_level_pre", 32'(level), 32'd4);
        m_ready = 1'b1;
        send(mk(8'h14));
        m_ready = 1'b0;
        check("fp_level", 32'(level), 32'd4);
        check("fp_overrun", 32'(overrun), 32'd0);
        check("fp_head", 32'(m_data), 32'h11);
        check("fp_fcnt", 32'(frame_cnt), 32'd13);
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("fp_pop_data", 32'(m_data), 32'(8'h10 + i));
            @(negedge clk);
        end
        check("fp_empty", 32'(m_valid), 32'd0);

        // Asynchronous reset mid-cycle with 3 entries queued
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(mk(8'(8'h20 + i)));
        end
        check("ar_level_pre", 32'(level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_level", 32'(level), 32'd0);
        check("ar_valid", 32'(m_valid), 32'd0);
        check("ar_data", 32'(m_data), 32'd0);
        check("ar_fcnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Counter saturation with error frames at full rate
        m_ready = 1'b1;
        frame_in = 11'h000;
        frame_valid = 1'b1;
        repeat (16'hFFFE) @(negedge clk);
        frame_valid = 1'b0;
        check("sat_fcnt_pre", 32'(frame_cnt), 32'hFFFE);
        check("sat_ecnt_pre", 32'(err_cnt), 32'hFFFE);
        check("sat_no_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 3; i++) begin
            send(11'h000);
        end
        check("sat_fcnt", 32'(frame_cnt), 32'hFFFF);
        check("sat_ecnt", 32'(err_cnt), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
